// File: rtl/led_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// led_arbiter_pkg
// Shared definitions for the LED arbiter slice.
//   state_t : arbiter FSM encoding (IDLE = nobody owns the LEDs, OWN = one owner)
//   LED_W   : width of the board LED bank and of each requester's pattern
//   PWM_W   : width of the optional dimming PWM counter / brightness input
// -----------------------------------------------------------------------------
package led_arbiter_pkg;

    localparam int LED_W = 8;
    localparam int PWM_W = 4;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

endpackage : led_arbiter_pkg

// File: rtl/led_arbiter_if.sv
// -----------------------------------------------------------------------------
// led_arbiter_if
// Bundles the requester-facing and LED-facing signals of led_arbiter.
//   req        : per-requester level request (N_REQ bits)
//   led_data   : requester i pattern in bits [8i+7:8i]
//   grant      : one-hot owner indication
//   led        : LED drive
//   busy       : high while any grant bit is set
//   brightness : dimming level, present only with LED_ARBITER_DIM_EN defined
// Modports: master drives requests (requester side / bench), slave is the
// arbiter itself.
// -----------------------------------------------------------------------------
interface led_arbiter_if #(
    parameter int N_REQ = 4
);
    import led_arbiter_pkg::*;

    logic [N_REQ-1:0]       req;
    logic [LED_W*N_REQ-1:0] led_data;
    logic [N_REQ-1:0]       grant;
    logic [LED_W-1:0]       led;
    logic                   busy;
`ifdef LED_ARBITER_DIM_EN
    logic [PWM_W-1:0]       brightness;
`endif

`ifdef LED_ARBITER_DIM_EN
    modport master (output req, output led_data, output brightness,
                    input grant, input led, input busy);
    modport slave  (input req, input led_data, input brightness,
                    output grant, output led, output busy);
`else
    modport master (output req, output led_data,
                    input grant, input led, input busy);
    modport slave  (input req, input led_data,
                    output grant, output led, output busy);
`endif

endinterface : led_arbiter_if

// File: rtl/led_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker: returns the first index at or after
// i_start (wrapping modulo N_REQ) whose request is set and not excluded.
//   i_req   : request vector
//   i_excl  : mask of indices that may not win (current owner on preemption)
//   i_start : index where the priority search begins
//   o_idx   : winning index (0 when o_valid is low)
//   o_valid : at least one eligible request exists
// -----------------------------------------------------------------------------
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [N_REQ-1:0] i_excl,
    input  logic [IDX_W-1:0] i_start,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_valid
);

    logic [N_REQ-1:0] w_cand;

    assign w_cand = i_req & ~i_excl;

    // Scan from farthest to nearest offset so the nearest candidate is written last and wins.
    always_comb begin
        int j;
        j       = 0;
        o_idx   = '0;
        o_valid = 1'b0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            j = int'(i_start) + k;
            if (j >= N_REQ) begin
                j = j - N_REQ;
            end else begin
                j = j;
            end
            if (w_cand[j]) begin
                o_idx   = IDX_W'(j);
                o_valid = 1'b1;
            end else begin
                o_idx   = o_idx;
            end
        end
    end

endmodule : rr_pick

// File: rtl/led_arbiter.sv
// -----------------------------------------------------------------------------
// led_arbiter
// Shares the 8 board LEDs between N_REQ requesters with round-robin grant and
// a maximum-hold quantum; shows IDLE_PATTERN while nobody owns the display.
//   clk   : system clock
//   rst_n : synchronous active-low reset
//   bus   : led_arbiter_if.slave (req, led_data in; grant, led, busy out;
//           brightness in when dimming is built in)
// Optional feature macro: LED_ARBITER_DIM_EN adds a 4-bit brightness input and
// a free-running PWM counter that gates the registered LED value.
// -----------------------------------------------------------------------------
module led_arbiter
    import led_arbiter_pkg::*;
#(
    parameter int                N_REQ        = 4,
    parameter logic [15:0]       MAX_HOLD     = 16'd50000,
    parameter logic [LED_W-1:0]  IDLE_PATTERN = 8'h01
) (
    input  logic         clk,
    input  logic         rst_n,
    led_arbiter_if.slave bus
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    state_t           r_state;
    state_t           w_next_state;
    logic [IDX_W-1:0] r_owner;
    logic [IDX_W-1:0] w_next_owner;
    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W-1:0] w_next_ptr;
    logic [15:0]      r_hold_cnt;
    logic [15:0]      w_next_hold;
    logic [N_REQ-1:0] r_grant;
    logic [N_REQ-1:0] w_next_grant;
    logic [LED_W-1:0] r_led;
    logic [LED_W-1:0] w_next_led;
    logic             r_busy;

    logic [N_REQ-1:0] w_excl;
    logic [IDX_W-1:0] w_pick_idx;
    logic             w_pick_valid;
    logic [IDX_W-1:0] w_pick_next;
    logic             w_take;
    logic [LED_W-1:0] w_owner_data;

    // While owning, the owner is masked so a pick always means "someone else is waiting".
    assign w_excl       = (r_state == OWN) ? r_grant : {N_REQ{1'b0}};
    assign w_owner_data = bus.led_data[int'(r_owner) * LED_W +: LED_W];
    assign w_pick_next  = (w_pick_idx == IDX_W'(N_REQ - 1)) ? {IDX_W{1'b0}}
                                                            : w_pick_idx + IDX_W'(1);

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .i_req   (bus.req),
        .i_excl  (w_excl),
        .i_start (r_ptr),
        .o_idx   (w_pick_idx),
        .o_valid (w_pick_valid)
    );

    // Next-state, grant handover, hold counting and LED source selection.
    always_comb begin
        w_next_state = r_state;
        w_next_owner = r_owner;
        w_next_ptr   = r_ptr;
        w_next_hold  = r_hold_cnt;
        w_next_grant = r_grant;
        w_next_led   = IDLE_PATTERN;
        w_take       = 1'b0;
        case (r_state)
            IDLE: begin
                w_next_led = IDLE_PATTERN;
                if (w_pick_valid) begin
                    w_take = 1'b1;
                end else begin
                    w_next_grant = {N_REQ{1'b0}};
                end
            end
            OWN: begin
                w_next_led = w_owner_data;
                if (!bus.req[r_owner]) begin
                    if (w_pick_valid) begin
                        w_take = 1'b1;
                    end else begin
                        w_next_state = IDLE;
                        w_next_grant = {N_REQ{1'b0}};
                        w_next_hold  = 16'd0;
                    end
                end else if ((MAX_HOLD != 16'd0) && (r_hold_cnt == MAX_HOLD) && w_pick_valid) begin
                    w_take = 1'b1;
                end else if (r_hold_cnt < MAX_HOLD) begin
                    w_next_hold = r_hold_cnt + 16'd1;
                end else begin
                    w_next_hold = MAX_HOLD;
                end
            end
            default: begin
                w_next_state = IDLE;
                w_next_grant = {N_REQ{1'b0}};
                w_next_hold  = 16'd0;
            end
        endcase
        // Any grant (fresh or handover) lands in OWN with a restarted quantum.
        if (w_take) begin
            w_next_state = OWN;
            w_next_owner = w_pick_idx;
            w_next_ptr   = w_pick_next;
            w_next_hold  = 16'd0;
            w_next_grant = {{(N_REQ - 1){1'b0}}, 1'b1} << w_pick_idx;
        end else begin
            w_next_owner = w_next_owner;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Datapath registers: owner, pointer, quantum counter and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_owner    <= {IDX_W{1'b0}};
            r_ptr      <= {IDX_W{1'b0}};
            r_hold_cnt <= 16'd0;
            r_grant    <= {N_REQ{1'b0}};
            r_busy     <= 1'b0;
            r_led      <= IDLE_PATTERN;
        end else begin
            r_owner    <= w_next_owner;
            r_ptr      <= w_next_ptr;
            r_hold_cnt <= w_next_hold;
            r_grant    <= w_next_grant;
            r_busy     <= |w_next_grant;
            r_led      <= w_next_led;
        end
    end

    assign bus.grant = r_grant;
    assign bus.busy  = r_busy;

`ifdef LED_ARBITER_DIM_EN
    logic [PWM_W-1:0] r_pwm_cnt;

    // Free-running PWM phase for dimming.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pwm_cnt <= {PWM_W{1'b0}};
        end else begin
            r_pwm_cnt <= r_pwm_cnt + PWM_W'(1);
        end
    end

    // Gate after the register so dimming adds no latency; brightness 0 blanks.
    assign bus.led = r_led & {LED_W{(r_pwm_cnt < bus.brightness)}};
`else
    assign bus.led = r_led;
`endif

endmodule : led_arbiter

// File: tb/tb_led_arbiter.sv
// -----------------------------------------------------------------------------
// tb_led_arbiter
// Directed bench for led_arbiter (N_REQ=4, MAX_HOLD=8, IDLE_PATTERN=8'h01).
// The driver applies one cycle of stimulus at a time and queues the outputs
// expected after the next clock edge; a monitor on the falling edge pops and
// compares them, and also checks that grant is never multi-hot.
// -----------------------------------------------------------------------------
module tb_led_arbiter;
    import led_arbiter_pkg::*;

    localparam int N = 4;

    typedef struct {
        int             cyc;
        logic [N-1:0]   grant;
        logic [7:0]     led;
        logic           busy;
        int             tid;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   pwm_base = 0;
    exp_t sb_q[$];
    exp_t mon_e;
    logic [7:0] dat [N];
    logic [7:0] prev_led;
    int   seq [5];

    led_arbiter_if #(.N_REQ(N)) bus ();

    led_arbiter #(
        .N_REQ        (N),
        .MAX_HOLD     (16'd8),
        .IDLE_PATTERN (8'h01)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Cycle stamp used to line expectations up with edges.
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: one-hot check every cycle plus scoreboard compare.
    always @(negedge clk) begin
        if (cyc > 0) begin
            checks = checks + 1;
            if (!$onehot0(bus.grant)) begin
                errors = errors + 1;
                $display("FAIL onehot cyc=%0d grant=%b required at most one bit set", cyc, bus.grant);
            end
        end
        while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
            mon_e  = sb_q.pop_front();
            checks = checks + 1;
            if (mon_e.cyc != cyc || bus.grant !== mon_e.grant ||
                bus.led !== mon_e.led || bus.busy !== mon_e.busy) begin
                errors = errors + 1;
                $display("FAIL t%0d cyc=%0d got grant=%b led=%h busy=%b, required grant=%b led=%h busy=%b",
                         mon_e.tid, cyc, bus.grant, bus.led, bus.busy,
                         mon_e.grant, mon_e.led, mon_e.busy);
            end
        end
    end

    task automatic load_data();
        for (int i = 0; i < N; i++) begin
            bus.led_data[i*8 +: 8] = dat[i];
        end
    endtask

    // Apply one cycle of inputs and queue what must appear after the next edge.
    task automatic step(input logic rst_v, input logic [N-1:0] r,
                        input logic [N-1:0] g, input logic [7:0] l, input int tid);
        exp_t e;
        rst_n   = rst_v;
        bus.req = r;
        e.cyc   = cyc + 1;
        e.grant = g;
        e.led   = l;
        e.busy  = |g;
        e.tid   = tid;
        if (!rst_v) pwm_base = cyc + 1;
`ifdef LED_ARBITER_DIM_EN
        if (((cyc + 1 - pwm_base) % 16) >= int'(bus.brightness)) e.led = 8'h00;
`endif
        sb_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

`ifdef LED_ARBITER_DIM_EN
    // Change brightness only between checks since it acts combinationally.
    task automatic set_bright(input logic [3:0] b);
        @(negedge clk);
        #1;
        bus.brightness = b;
        @(posedge clk);
        #1;
    endtask
`endif

    initial begin
        dat[0] = 8'h11; dat[1] = 8'h22; dat[2] = 8'hA5; dat[3] = 8'h44;
        seq[0] = 0; seq[1] = 1; seq[2] = 2; seq[3] = 3; seq[4] = 0;
        rst_n   = 1'b0;
        bus.req = 4'b0000;
        load_data();
`ifdef LED_ARBITER_DIM_EN
        bus.brightness = 4'd15;
`endif
        @(posedge clk);
        #1;

        // T1: reset state, then idle pattern steady for 20 cycles.
        step(1'b0, 4'b0000, 4'b0000, 8'h01, 1);
        step(1'b0, 4'b0000, 4'b0000, 8'h01, 1);
        for (int i = 0; i < 20; i++) step(1'b1, 4'b0000, 4'b0000, 8'h01, 1);

        // T2: single requester 2; LED follows one cycle after grant.
        step(1'b1, 4'b0100, 4'b0100, 8'h01, 2);
        step(1'b1, 4'b0100, 4'b0100, 8'hA5, 2);
        step(1'b1, 4'b0100, 4'b0100, 8'hA5, 2);
        step(1'b1, 4'b0000, 4'b0000, 8'hA5, 2);
        step(1'b1, 4'b0000, 4'b0000, 8'h01, 2);

        // T1b: reset during ownership drops the grant on that edge.
        step(1'b1, 4'b0100, 4'b0100, 8'h01, 7);
        step(1'b1, 4'b0100, 4'b0100, 8'hA5, 7);
        step(1'b0, 4'b0100, 4'b0000, 8'h01, 7);
        step(1'b1, 4'b0000, 4'b0000, 8'h01, 7);

        // T3: all request; each owner holds 9 cycles, order 0,1,2,3,0, no gaps.
        prev_led = 8'h01;
        for (int s = 0; s < 5; s++) begin
            for (int c = 0; c < 9; c++) begin
                step(1'b1, 4'b1111, 4'b0001 << seq[s], prev_led, 3);
                prev_led = dat[seq[s]];
            end
        end
        step(1'b1, 4'b0000, 4'b0000, 8'h11, 3);
        step(1'b1, 4'b0000, 4'b0000, 8'h01, 3);

        // T4: owner 1 alone past saturation, then requester 3 preempts at once.
        step(1'b1, 4'b0010, 4'b0010, 8'h01, 4);
        for (int i = 0; i < 30; i++) step(1'b1, 4'b0010, 4'b0010, 8'h22, 4);
        step(1'b1, 4'b1010, 4'b1000, 8'h22, 4);
        step(1'b1, 4'b1010, 4'b1000, 8'h44, 4);
        step(1'b1, 4'b0000, 4'b0000, 8'h44, 4);
        step(1'b1, 4'b0000, 4'b0000, 8'h01, 4);

        // T5: owner 0 releases while 2 waits: direct handover on one edge.
        step(1'b1, 4'b0001, 4'b0001, 8'h01, 5);
        step(1'b1, 4'b0101, 4'b0001, 8'h11, 5);
        step(1'b1, 4'b0100, 4'b0100, 8'h11, 5);
        step(1'b1, 4'b0100, 4'b0100, 8'hA5, 5);
        step(1'b1, 4'b0000, 4'b0000, 8'hA5, 5);
        step(1'b1, 4'b0000, 4'b0000, 8'h01, 5);

`ifdef LED_ARBITER_DIM_EN
        // T6: dimming at brightness 4 and 0 with owner data 8'hFF.
        dat[0] = 8'hFF;
        load_data();
        set_bright(4'd4);
        step(1'b1, 4'b0001, 4'b0001, 8'h01, 6);
        for (int i = 0; i < 32; i++) step(1'b1, 4'b0001, 4'b0001, 8'hFF, 6);
        set_bright(4'd0);
        for (int i = 0; i < 16; i++) step(1'b1, 4'b0001, 4'b0001, 8'hFF, 6);
`endif

        // Let the monitor drain the queue within a bounded number of cycles.
        for (int k = 0; k < 10 && sb_q.size() > 0; k++) @(posedge clk);
        if (sb_q.size() > 0) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL drain pending=%0d required 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_led_arbiter

// File: doc/led_arbiter.md
Name: led_arbiter

Overview:
- Shares the board's 8 user LEDs between up to N_REQ internal requesters, e.g. heartbeat counter, UART RX/TX activity, and error codes.
- Round-robin grant with a maximum-hold quantum, so one source cannot monopolise the display.
- Sits between requester logic and the top-level `led` output.
- Shows a fixed idle pattern when no requester owns the LEDs.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- MAX_HOLD, 16'd50000, cycles an owner may keep the LEDs while others wait; 0 disables preemption.
- IDLE_PATTERN, 8'h01, LED value driven while no owner.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  synchronous active-low reset.
- req  input  N_REQ  per-requester ownership request, level.
- led_data  input  8*N_REQ  requester i pattern in bits [8i+7:8i].
- grant  output  N_REQ  one-hot owner indication, registered.
- led  output  8  LED drive, registered.
- busy  output  1  high while any grant bit is set.

Behaviour:
- Reset:
  - One clock and one reset, named `clk` and `rst_n`; reset is synchronous and active-low.
  - On any clk edge with rst_n=0: grant=0, busy=0, led=IDLE_PATTERN, rr pointer=0, hold_cnt=0, state=IDLE.
  - A reset mid-ownership drops the grant on that edge.
- States: IDLE, OWN.
- IDLE:
  - led<=IDLE_PATTERN every cycle.
  - If any req=1 at edge t: pick the first requesting index at or after ptr, wrapping modulo N_REQ.
  - At t+1: grant one-hot set, state=OWN, hold_cnt=0, ptr=winner+1 (wraps).
- OWN, owner index o:
  - led<=led_data[o] every cycle, so led reflects the owner's data one cycle after grant rises.
  - hold_cnt increments each cycle and saturates at MAX_HOLD.
  - Release: req[o]=0 at edge t.
    - If other req pending, grant moves directly to the rr winner at t+1: old bit clears and new bit sets on the same edge, no gap cycle, hold_cnt=0.
    - Otherwise grant=0 and state=IDLE at t+1.
  - Preempt: MAX_HOLD!=0, hold_cnt==MAX_HOLD and another req pending.
    - Grant moves to the rr winner among the others at t+1, hold_cnt=0.
    - The preempted owner keeps req high and re-competes normally.
  - No other requester pending at saturation: owner retains the grant; hold_cnt stays saturated.
- Round-robin rules:
  - Priority search starts at ptr.
  - The current owner is excluded from the search on preemption.
  - Single-requester case: that requester is re-granted indefinitely.
- Outputs:
  - grant is never multi-hot.
  - busy = |grant, registered alongside grant.
- Widths: hold_cnt is 16 bits; owner index is $clog2(N_REQ) bits.

Optional Feature:
- Macro: LED_ARBITER_DIM_EN.
- Defined:
  - Adds port `brightness` (input, 4 bits).
  - A free-running 4-bit pwm counter is added.
  - led output is AND-gated with (pwm_cnt < brightness), giving 16 duty levels; brightness=0 blanks the LEDs.
  - Gating applies after the led register and adds no latency; pwm_cnt resets to 0.
- Undefined: no brightness port and no gating; led is the raw registered value.

Decomposition:
- Package led_arbiter_pkg:
  - state encoding typedef (IDLE, OWN).
  - LED_W=8 constant.
  - PWM_W=4 constant.
- Sub-module rr_pick:
  - Combinational.
  - Inputs: request vector, start pointer, exclude mask.
  - Outputs: winner index and a valid flag.
  - Reused for both idle arbitration and handover.

Test Plan (N_REQ=4, MAX_HOLD=8, IDLE_PATTERN=8'h01):
1. Reset then no req -> grant=4'b0000, busy=0, led=8'h01 steady for 20 cycles; mid-OWN rst_n low one cycle -> grant=0, led=8'h01 next edge.
2. req=4'b0100, led_data[2]=8'hA5 -> grant=4'b0100 one cycle later, led=8'hA5 the following cycle; drop req -> grant=0, led=8'h01.
3. req=4'b1111 held, all data distinct -> grant sequence 0,1,2,3,0, each owner exactly 9 cycles (hold_cnt 0..8), no gap cycles.
4. Owner 1 alone for 30 cycles -> grant stays 4'b0010; req[3] rises -> grant=4'b1000 next edge (hold_cnt already saturated).
5. Owner 0 drops req while req[2] high -> grant 4'b0001 to 4'b0100 on a single edge, never 0 or multi-hot (assert one-hot each cycle).
6. LED_ARBITER_DIM_EN, brightness=4, owner data 8'hFF -> led=8'hFF for 4 of every 16 cycles, 0 otherwise; brightness=0 -> led=0.
